// File: rtl/dft_stream_core_pkg.sv
// rtl/dft_stream_core_pkg.sv - shared types and helpers for the DFT stream core
package dft_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_CALC = 2'd1,
    ST_OUT  = 2'd2
  } dft_state_e;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/dft_stream_core_if.sv
// rtl/dft_stream_core_if.sv - sample input and bin output handshake bundle
interface dft_stream_core_if #(
  parameter int W = 16
);
  logic                mode;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_re;
  logic signed [W-1:0] in_im;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_re;
  logic signed [W-1:0] out_im;
  logic                out_last;

  modport slave (
    input  mode, in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_last
  );

  modport master (
    output mode, in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_last
  );
endinterface

// File: rtl/dft_twiddle_rom.sv
// rtl/dft_twiddle_rom.sv - registered cos/sin table, quantised Q1.(TW-1) at elaboration
module dft_twiddle_rom import dft_pkg::*; #(
  parameter int N  = 8,
  parameter int TW = 16
) (
  input  logic                   clk,
  input  logic [clog2(N)-1:0]    idx_i,
  output logic signed [TW-1:0]   cos_o,
  output logic signed [TW-1:0]   sin_o
);

  localparam real PI   = 3.14159265358979323846;
  localparam real SC   = 2.0 ** (TW - 1);
  localparam int  QMAX = (1 << (TW - 1)) - 1;
  localparam int  QMIN = -(1 << (TW - 1));

  logic signed [TW-1:0] cos_tab [N];
  logic signed [TW-1:0] sin_tab [N];

  // int'() rounds to nearest; cos(0) lands on 2^(TW-1) and is clamped.
  for (genvar i = 0; i < N; i++) begin : g_tab
    localparam real CR = $cos(2.0 * PI * i / N) * SC;
    localparam real SR = $sin(2.0 * PI * i / N) * SC;
    localparam int  CI = int'(CR);
    localparam int  SI = int'(SR);
    localparam int  CQ = (CI > QMAX) ? QMAX : ((CI < QMIN) ? QMIN : CI);
    localparam int  SQ = (SI > QMAX) ? QMAX : ((SI < QMIN) ? QMIN : SI);
    assign cos_tab[i] = TW'(CQ);
    assign sin_tab[i] = TW'(SQ);
  end

  always_ff @(posedge clk) begin
    cos_o <= cos_tab[idx_i];
    sin_o <= sin_tab[idx_i];
  end

endmodule

// File: rtl/dft_stream_core.sv
// rtl/dft_stream_core.sv - frame-buffered direct DFT/IDFT, one complex MAC per cycle
module dft_stream_core import dft_pkg::*; #(
  parameter int N         = 8,
  parameter int W         = 16,
  parameter int TW        = 16,
  parameter int SCALE_INV = 1
) (
  input logic             clk,
  input logic             rst_n,
  dft_stream_core_if.slave bus
);

  localparam int LOGN = clog2(N);
  localparam int PW   = W + TW;
  localparam int AW   = W + TW + LOGN + 1;
  localparam int SF   = TW - 1;
  localparam int SI   = TW - 1 + LOGN;
  localparam logic [LOGN-1:0] NM1 = LOGN'(N - 1);

  dft_state_e           state_q;
  logic [LOGN-1:0]      n_q, k_q, idx_q;
  logic                 iss_q, mac_v_q, mac_last_q, mode_q;
  logic                 in_ready_q, out_valid_q, out_last_q;
  logic signed [W-1:0]  buf_re_q [N];
  logic signed [W-1:0]  buf_im_q [N];
  logic signed [W-1:0]  xr_q, xi_q, out_re_q, out_im_q;
  logic signed [AW-1:0] acc_re_q, acc_im_q;

  logic signed [TW-1:0] cos_w, sin_w;
  logic signed [PW-1:0] p_rc, p_is, p_ic, p_rs;
  logic signed [AW-1:0] term_re_d, term_im_d, acc_re_d, acc_im_d, sh_re, sh_im;
  logic signed [W-1:0]  out_re_d, out_im_d;
  logic                 accept_in;

  // ROM output and xr_q/xi_q are both one cycle behind idx_q/n_q, so they line up.
  dft_twiddle_rom #(.N(N), .TW(TW)) u_rom (
    .clk   (clk),
    .idx_i (idx_q),
    .cos_o (cos_w),
    .sin_o (sin_w)
  );

  assign accept_in = (state_q == ST_LOAD) && bus.in_valid && in_ready_q;

  assign p_rc = PW'(xr_q) * PW'(cos_w);
  assign p_is = PW'(xi_q) * PW'(sin_w);
  assign p_ic = PW'(xi_q) * PW'(cos_w);
  assign p_rs = PW'(xr_q) * PW'(sin_w);

  assign term_re_d = (mode_q == MODE_INV) ? AW'(p_rc) - AW'(p_is) : AW'(p_rc) + AW'(p_is);
  assign term_im_d = (mode_q == MODE_INV) ? AW'(p_ic) + AW'(p_rs) : AW'(p_ic) - AW'(p_rs);
  assign acc_re_d  = acc_re_q + term_re_d;
  assign acc_im_d  = acc_im_q + term_im_d;

  assign sh_re    = (SCALE_INV != 0 && mode_q == MODE_INV) ? (acc_re_d >>> SI) : (acc_re_d >>> SF);
  assign sh_im    = (SCALE_INV != 0 && mode_q == MODE_INV) ? (acc_im_d >>> SI) : (acc_im_d >>> SF);
  assign out_re_d = W'(saturate(64'(sh_re), W));
  assign out_im_d = W'(saturate(64'(sh_im), W));

  always_ff @(posedge clk) begin
    if (accept_in) begin
      buf_re_q[n_q] <= bus.in_re;
      buf_im_q[n_q] <= bus.in_im;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      n_q         <= '0;
      k_q         <= '0;
      idx_q       <= '0;
      iss_q       <= 1'b0;
      mac_v_q     <= 1'b0;
      mac_last_q  <= 1'b0;
      mode_q      <= MODE_FWD;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      xr_q        <= '0;
      xi_q        <= '0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          in_ready_q <= 1'b1;
          if (accept_in) begin
            if (n_q == '0) mode_q <= bus.mode;
            n_q <= n_q + 1'b1;
            if (n_q == NM1) begin
              in_ready_q <= 1'b0;
              k_q        <= '0;
              idx_q      <= '0;
              acc_re_q   <= '0;
              acc_im_q   <= '0;
              iss_q      <= 1'b1;
              state_q    <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          mac_v_q    <= iss_q;
          mac_last_q <= iss_q && (n_q == NM1);
          if (iss_q) begin
            xr_q  <= buf_re_q[n_q];
            xi_q  <= buf_im_q[n_q];
            n_q   <= n_q + 1'b1;
            idx_q <= idx_q + k_q;
            if (n_q == NM1) iss_q <= 1'b0;
          end
          if (mac_v_q) begin
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
          end
          // The final term is folded straight into the registered output.
          if (mac_last_q) begin
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_valid_q <= 1'b1;
            out_last_q  <= (k_q == NM1);
            state_q     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (k_q == NM1) begin
              k_q        <= '0;
              in_ready_q <= 1'b1;
              state_q    <= ST_LOAD;
            end else begin
              k_q      <= k_q + 1'b1;
              acc_re_q <= '0;
              acc_im_q <= '0;
              idx_q    <= '0;
              n_q      <= '0;
              iss_q    <= 1'b1;
              state_q  <= ST_CALC;
            end
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_re    = out_re_q;
  assign bus.out_im    = out_im_q;

endmodule
